button_debounce: RTL

//   Upstream conditioning stage for the Hack GPIO buttons: synchronises raw active-low pad inputs,

---
 rtl/button_pkg.sv | 15 +
 rtl/debounce_channel.sv | 148 ++++++++++++++
 rtl/button_debounce.sv | 34 +++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and defaults for the button debounce block.
package button_pkg;

    typedef enum logic [1:0] {
        StReleased    = 2'd0,
        StPendPress   = 2'd1,
        StPressed     = 2'd2,
        StPendRelease = 2'd3
    } btn_state_t;

    localparam int unsigned SYNC_STAGES         = 2;
    localparam int unsigned DEFAULT_DB_CYCLES   = 1_000_000;
    localparam int unsigned DEFAULT_LONG_CYCLES = 100_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: pad synchroniser, debounce FSM and optional long-press detector.
// Long-press logic is built only when BUTTON_LONG_PRESS_EN is defined.
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DEFAULT_DB_CYCLES,
    parameter int unsigned LONG_CYCLES = DEFAULT_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic but,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    if (DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES) begin : g_bad_params
        $error("debounce_channel: need DB_CYCLES >= 2 and LONG_CYCLES > DB_CYCLES");
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam int unsigned CNT_W = $clog2(LONG_CYCLES + 1);
`else
    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
`endif
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    btn_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   s;
    logic                   db_done;

    // Pad is active-low; sync flops reset to the released level.
    assign s       = ~sync_q[SYNC_STAGES-1];
    assign db_done = (cnt_q == DB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            state_q   <= StReleased;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], but};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            StReleased: begin
                if (s) begin
                    state_d = StPendPress;
                    cnt_d   = CNT_W'(1);
                end
            end
            StPendPress: begin
                if (!s) begin
                    state_d = StReleased;
                end else if (db_done) begin
                    state_d = StPressed;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StPressed: begin
                if (!s) begin
                    state_d = StPendRelease;
                    cnt_d   = CNT_W'(1);
                end
            end
            StPendRelease: begin
                if (s) begin
                    state_d = StPressed;
                end else if (db_done) begin
                    state_d = StReleased;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StReleased;
        endcase
    end

    always_comb begin
        press_d   = (state_q == StPendPress) && s && db_done;
        release_d = (state_q == StPendRelease) && !s && db_done;
        level_d   = level_q;
        if (press_d) begin
            level_d = 1'b1;
        end else if (release_d) begin
            level_d = 1'b0;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int unsigned      HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Runs while the debounced level is high, so a rejected release glitch keeps the count.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d) begin
            hold_d = '0;
        end else if (level_q && hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
            long_d = (hold_q == LONG_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Debounced, edge-detected button inputs: N_BTN independent debounce_channel instances.
// Define BUTTON_LONG_PRESS_EN to enable the btn_long long-press pulses.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned N_BTN       = 2,
    parameter int unsigned DB_CYCLES   = DEFAULT_DB_CYCLES,
    parameter int unsigned LONG_CYCLES = DEFAULT_LONG_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] but,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .DB_CYCLES   (DB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .but         (but[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_long    (btn_long[i])
        );
    end

endmodule
